mem_access_stage: RTL
=====================

Name: mem_access_stage

Overview:
- Memory stage of the RISC-V core, directly downstream of execute.
- Consumes one execute result per handshake: iType/memFunc/dst/data/addr, using the ExecInst field set and ProcTypes enums.
- Drives a single-outstanding word-wide data-memory bus with byte enables. Handles store-lane alignment, load extraction and sign/zero extension, misalignment detection and response timeout.
- Presents a writeback record to the register-file writeback stage through a valid/ready handshake.

Parameters:
- RESP_TIMEOUT, 255, max cycles waited in RESP for mem_resp_valid; 0 disables the timeout.

Ports:
- clk_in  input  1  clock
- rst_n_in  input  1  asynchronous active-low reset
- ex_valid_in  input  1  execute result valid
- ex_ready_out  output  1  stage can accept result
- ex_mem_func_in  input  ProcTypes::MemFunc  Lw..Sb, or NopM for non-memory
- ex_dst_in  input  5  destination register
- ex_data_in  input  32  ALU result (NopM) or store value (stores)
- ex_addr_in  input  32  byte address (loads/stores)
- mem_req_valid_out  output  1  bus request valid
- mem_req_ready_in  input  1  bus accepts request
- mem_req_addr_out  output  32  word address, {addr[31:2],2'b00}
- mem_req_wen_out  output  1  1 = write
- mem_req_be_out  output  4  byte enables
- mem_req_wdata_out  output  32  lane-aligned write data
- mem_resp_valid_in  input  1  read data valid (single-cycle pulse)
- mem_resp_rdata_in  input  32  read word
- wb_valid_out  output  1  writeback record valid
- wb_ready_in  input  1  writeback consumer ready
- wb_we_out  output  1  write register file
- wb_dst_out  output  5  destination register
- wb_data_out  output  32  writeback data
- wb_misaligned_out  output  1  access was misaligned, no bus access made
- wb_bus_err_out  output  1  load timed out

Behaviour:
- Reset: asynchronous on rst_n_in low, from any state. State=IDLE; all *_valid_out=0; wb_we/misaligned/bus_err=0; data/addr/be outputs=0; timeout counter=0.
- ex_ready_out = (state==IDLE). Input is captured into internal registers on ex_valid_in && ex_ready_out.
- FSM states: IDLE, REQ, RESP, WB.
- IDLE, on accept:
  - NopM -> WB with wb_we=1, wb_data=ex_data_in.
  - Misaligned -> WB with wb_we=0, misaligned=1.
  - Otherwise -> REQ.
- Misalignment rules:
  - Lw/Sw: addr[1:0]!=0.
  - Lh/Lhu/Sh: addr[0]=1.
  - Byte accesses: never misaligned.
- REQ: mem_req_valid_out=1 and all request fields held stable until mem_req_ready_in. On accept: loads -> RESP; stores -> WB with wb_we=0.
- Store lanes:
  - Sw: be=4'b1111, wdata=data.
  - Sh: be=4'b0011 (addr[1]=0) or 4'b1100 (addr[1]=1), wdata={2{data[15:0]}}.
  - Sb: be=4'b0001<<addr[1:0], wdata={4{data[7:0]}}.
- Loads: wen=0, be=4'b1111.
- RESP: counter increments each cycle.
  - On mem_resp_valid_in: extract the lane by addr[1:0]/addr[1], sign-extend for Lb/Lh and zero-extend for Lbu/Lhu, Lw passes through. Go to WB with wb_we=1, bus_err=0.
  - If RESP_TIMEOUT!=0 and the counter reaches RESP_TIMEOUT with no response: go to WB with wb_we=0, wb_data=0, bus_err=1.
  - A response in the same cycle the counter hits the limit counts as the response and wins.
- WB: wb_valid_out=1 and all wb fields stable until wb_ready_in; then -> IDLE.
  - Latency is 1 cycle for NopM/misaligned: wb_valid the cycle after accept.
  - A zero-wait load with mem_req_ready and mem_resp_valid each one cycle after the prior step gives wb_valid 3 cycles after accept.
  - A back-to-back accept requires IDLE, so peak throughput is one instruction per 2 cycles.
- mem_resp_valid_in outside RESP is ignored, including late responses after a timeout or reset.
- dst=0 still reports wb_we as specified; the register file ignores x0.

Test Plan:
- NopM, data=0x1234_5678, dst=5 -> next cycle wb_valid=1, we=1, dst=5, data=0x1234_5678; no mem_req_valid ever.
- Sb addr=0x103, data=0xAB -> req addr=0x100, wen=1, be=4'b1000, wdata=0xABAB_ABAB. Hold mem_req_ready=0 for 3 cycles: fields stable throughout. Then wb we=0.
- Lb addr=0x102, rdata=0x0080_0000 -> wb_data=0xFFFF_FF80. Repeat with Lbu -> 0x0000_0080. Lh addr=0x102, rdata=0x8001_0000 -> 0xFFFF_8001.
- Lw addr=0x101 -> no bus request; wb misaligned=1, we=0. Sh addr=0x203 -> misaligned. Lh addr=0x202 -> legal.
- RESP_TIMEOUT=4, Lw with no response -> wb bus_err=1, we=0, data=0. A late mem_resp_valid pulse in IDLE is ignored, and the next Lw returns correct data.
- Assert rst_n_in low while in RESP -> outputs clear asynchronously, ex_ready_out=1 after release, and a stale mem_resp_valid after release produces no wb_valid.

Source files
------------

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//
// Memory stage of the RISC-V core, directly downstream of execute. It takes
// one execute result per handshake and, depending on its memory function:
//   - NopM       : forwards the ALU result straight to writeback
//   - misaligned : reports the fault to writeback without touching the bus
//   - load/store : performs a single-outstanding word access with byte enables,
//                  aligning store lanes and extracting/extending load lanes
// A response timeout turns a stuck load into a bus-error writeback record.
//
// Ports
//   clk_in, rst_n_in       clock, asynchronous active-low reset
//   ex_*                   execute result valid/ready handshake and fields
//   mem_req_*              data-memory request (held stable until ready)
//   mem_resp_*             read data return (single-cycle pulse)
//   wb_*                   writeback record valid/ready handshake and fields
//
// Parameter
//   RESP_TIMEOUT           max cycles waited for a read response, 0 = forever
// -----------------------------------------------------------------------------
package ProcTypes;
   typedef enum logic [3:0] {
      NopM, Lw, Lh, Lhu, Lb, Lbu, Sw, Sh, Sb
   } MemFunc;
endpackage

module mem_access_stage #(
   parameter int RESP_TIMEOUT = 255
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic              ex_valid_in,
   output logic              ex_ready_out,
   input  ProcTypes::MemFunc ex_mem_func_in,
   input  logic [4:0]        ex_dst_in,
   input  logic [31:0]       ex_data_in,
   input  logic [31:0]       ex_addr_in,
   output logic              mem_req_valid_out,
   input  logic              mem_req_ready_in,
   output logic [31:0]       mem_req_addr_out,
   output logic              mem_req_wen_out,
   output logic [3:0]        mem_req_be_out,
   output logic [31:0]       mem_req_wdata_out,
   input  logic              mem_resp_valid_in,
   input  logic [31:0]       mem_resp_rdata_in,
   output logic              wb_valid_out,
   input  logic              wb_ready_in,
   output logic              wb_we_out,
   output logic [4:0]        wb_dst_out,
   output logic [31:0]       wb_data_out,
   output logic              wb_misaligned_out,
   output logic              wb_bus_err_out
);
   import ProcTypes::*;

   typedef enum logic [1:0] {IDLE, REQ, RESP, WB} StateT;

   localparam int            CW         = (RESP_TIMEOUT < 2) ? 1 : $clog2(RESP_TIMEOUT + 1);
   localparam bit            TIMEOUT_EN = (RESP_TIMEOUT != 0);
   // Counter value in the last permitted RESP cycle; the counter starts at 0
   // on RESP entry, so this allows exactly RESP_TIMEOUT cycles of waiting.
   localparam logic [CW-1:0] CNT_LAST   = CW'(RESP_TIMEOUT - 1);

   StateT          stateReg, stateNext;
   MemFunc         funcReg, funcNext;
   logic [1:0]     addrLoReg, addrLoNext;
   logic [CW-1:0]  cntReg, cntNext;
   logic [31:0]    reqAddrReg, reqAddrNext;
   logic           reqWenReg, reqWenNext;
   logic [3:0]     reqBeReg, reqBeNext;
   logic [31:0]    reqWdataReg, reqWdataNext;
   logic           wbWeReg, wbWeNext;
   logic [4:0]     wbDstReg, wbDstNext;
   logic [31:0]    wbDataReg, wbDataNext;
   logic           wbMisReg, wbMisNext;
   logic           wbErrReg, wbErrNext;

   logic           exMisaligned;
   logic           exIsStore;
   logic [3:0]     exBe;
   logic [31:0]    exWdata;
   logic           regIsStore;
   logic [7:0]     loadByte;
   logic [15:0]    loadHalf;
   logic [31:0]    loadData;

   assign ex_ready_out      = (stateReg == IDLE);
   assign mem_req_valid_out = (stateReg == REQ);
   assign wb_valid_out      = (stateReg == WB);

   assign mem_req_addr_out  = reqAddrReg;
   assign mem_req_wen_out   = reqWenReg;
   assign mem_req_be_out    = reqBeReg;
   assign mem_req_wdata_out = reqWdataReg;
   assign wb_we_out         = wbWeReg;
   assign wb_dst_out        = wbDstReg;
   assign wb_data_out       = wbDataReg;
   assign wb_misaligned_out = wbMisReg;
   assign wb_bus_err_out    = wbErrReg;

   assign exIsStore  = (ex_mem_func_in == Sw) || (ex_mem_func_in == Sh) || (ex_mem_func_in == Sb);
   assign regIsStore = (funcReg == Sw) || (funcReg == Sh) || (funcReg == Sb);

   // Alignment check and store lane placement, decoded from the incoming
   // execute result so the request registers are loaded ready to go.
   always_comb begin
      exMisaligned = 1'b0;
      exBe         = 4'b1111;
      exWdata      = 32'h0;
      case (ex_mem_func_in)
         Lw, Sw:      exMisaligned = (ex_addr_in[1:0] != 2'b00);
         Lh, Lhu, Sh: exMisaligned = ex_addr_in[0];
         default:     exMisaligned = 1'b0;
      endcase
      case (ex_mem_func_in)
         Sw: begin
            exBe    = 4'b1111;
            exWdata = ex_data_in;
         end
         Sh: begin
            exBe    = ex_addr_in[1] ? 4'b1100 : 4'b0011;
            exWdata = {2{ex_data_in[15:0]}};
         end
         Sb: begin
            exBe    = 4'b0001 << ex_addr_in[1:0];
            exWdata = {4{ex_data_in[7:0]}};
         end
         default: begin
            exBe    = 4'b1111;
            exWdata = 32'h0;
         end
      endcase
   end

   // Load lane extraction from the returned word using the captured offset.
   always_comb begin
      loadByte = 8'(mem_resp_rdata_in >> {addrLoReg, 3'b000});
      loadHalf = addrLoReg[1] ? mem_resp_rdata_in[31:16] : mem_resp_rdata_in[15:0];
      case (funcReg)
         Lb:      loadData = {{24{loadByte[7]}}, loadByte};
         Lbu:     loadData = {24'h0, loadByte};
         Lh:      loadData = {{16{loadHalf[15]}}, loadHalf};
         Lhu:     loadData = {16'h0, loadHalf};
         default: loadData = mem_resp_rdata_in;
      endcase
   end

   // Next-state and datapath-next logic.
   always_comb begin
      stateNext    = stateReg;
      funcNext     = funcReg;
      addrLoNext   = addrLoReg;
      cntNext      = cntReg;
      reqAddrNext  = reqAddrReg;
      reqWenNext   = reqWenReg;
      reqBeNext    = reqBeReg;
      reqWdataNext = reqWdataReg;
      wbWeNext     = wbWeReg;
      wbDstNext    = wbDstReg;
      wbDataNext   = wbDataReg;
      wbMisNext    = wbMisReg;
      wbErrNext    = wbErrReg;

      case (stateReg)
         IDLE: begin
            if (ex_valid_in) begin
               funcNext   = ex_mem_func_in;
               addrLoNext = ex_addr_in[1:0];
               wbDstNext  = ex_dst_in;
               wbMisNext  = 1'b0;
               wbErrNext  = 1'b0;
               if (ex_mem_func_in == NopM) begin
                  wbWeNext   = 1'b1;
                  wbDataNext = ex_data_in;
                  stateNext  = WB;
               end else if (exMisaligned) begin
                  wbWeNext   = 1'b0;
                  wbDataNext = 32'h0;
                  wbMisNext  = 1'b1;
                  stateNext  = WB;
               end else begin
                  reqAddrNext  = {ex_addr_in[31:2], 2'b00};
                  reqWenNext   = exIsStore;
                  reqBeNext    = exBe;
                  reqWdataNext = exWdata;
                  stateNext    = REQ;
               end
            end
         end
         REQ: begin
            if (mem_req_ready_in) begin
               if (regIsStore) begin
                  wbWeNext   = 1'b0;
                  wbDataNext = 32'h0;
                  stateNext  = WB;
               end else begin
                  cntNext   = '0;
                  stateNext = RESP;
               end
            end
         end
         RESP: begin
            cntNext = cntReg + 1'b1;
            // A response arriving on the limit cycle still wins.
            if (mem_resp_valid_in) begin
               wbWeNext   = 1'b1;
               wbDataNext = loadData;
               wbErrNext  = 1'b0;
               stateNext  = WB;
            end else if (TIMEOUT_EN && (cntReg == CNT_LAST)) begin
               wbWeNext   = 1'b0;
               wbDataNext = 32'h0;
               wbErrNext  = 1'b1;
               stateNext  = WB;
            end
         end
         WB: begin
            if (wb_ready_in) begin
               stateNext = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         stateReg    <= IDLE;
         funcReg     <= NopM;
         addrLoReg   <= 2'b00;
         cntReg      <= '0;
         reqAddrReg  <= 32'h0;
         reqWenReg   <= 1'b0;
         reqBeReg    <= 4'h0;
         reqWdataReg <= 32'h0;
         wbWeReg     <= 1'b0;
         wbDstReg    <= 5'h0;
         wbDataReg   <= 32'h0;
         wbMisReg    <= 1'b0;
         wbErrReg    <= 1'b0;
      end else begin
         stateReg    <= stateNext;
         funcReg     <= funcNext;
         addrLoReg   <= addrLoNext;
         cntReg      <= cntNext;
         reqAddrReg  <= reqAddrNext;
         reqWenReg   <= reqWenNext;
         reqBeReg    <= reqBeNext;
         reqWdataReg <= reqWdataNext;
         wbWeReg     <= wbWeNext;
         wbDstReg    <= wbDstNext;
         wbDataReg   <= wbDataNext;
         wbMisReg    <= wbMisNext;
         wbErrReg    <= wbErrNext;
      end
   end
endmodule
